block_drop_controller: RTL and testbench
========================================

Name: block_drop_controller

Overview:
- Producer side of the overlap check. Generates the moving block's x position and the x position of the previous row's block, which feed the overlap detector.
- Sweeps the current block left and right, freezes it on a drop request, and samples the detector's registered verdict.
- On a hit, commits the row; on a miss or a full tower, ends the round.
- Sits between the player input synchroniser and the game logic / VGA draw path.

Parameters:
X_MAX, 150, largest legal curr_x_position (left edge of a 10-px block on a 160-px screen)
START_X, 75, x position of the base platform, loaded into prev_x_position at reset/restart
TICK_DIV, 833333, clk cycles per movement tick (60 Hz at 50 MHz)
ROWS, 12, rows to place for a win (max 15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
drop  in  1  single-cycle pulse, already synchronised, player drop request
restart  in  1  single-cycle pulse, starts a new round from DONE
overlap_q  in  1  registered output of the overlap detector
curr_x_position  out  8  x of the moving/dropped block
prev_x_position  out  8  x of the last placed block (or base)
row  out  4  number of rows placed so far
check  out  1  high while the FSM is in LATCH (positions frozen for the detector)
placed  out  1  one-cycle pulse when a row is committed
game_over  out  1  level, high in DONE after a miss
win  out  1  level, high in DONE after ROWS rows

Behaviour:
- Reset (async, any state): state=MOVE, curr=0, dir=right, prev=START_X, row=0, tick counter=0. check, placed, game_over and win are all 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 in MOVE only; tick is asserted at TICK_DIV-1, then the counter wraps to 0.
  - The counter is cleared on every entry to MOVE.
- Step size = 1 + row[3:2] (speeds up every 4 rows); range 1..4.
- MOVE:
  - On tick, dir right: if curr+step >= X_MAX, then curr=X_MAX and dir=left; else curr += step.
  - On tick, dir left: if curr <= step, then curr=0 and dir=right; else curr -= step.
  - Arithmetic uses 9 bits internally; curr never leaves 0..X_MAX.
  - drop -> LATCH. If drop and tick coincide, drop wins and curr is not updated that cycle.
- LATCH (1 cycle):
  - check=1; curr and prev are held.
  - The detector registers its verdict at the end of this cycle. Next state is EVAL.
- EVAL (1 cycle): sample overlap_q.
  - overlap_q=1: prev<=curr, row<=row+1, placed=1.
    - If row+1 == ROWS: -> DONE with win=1.
    - Else: -> MOVE with curr=0 and dir=right.
  - overlap_q=0: -> DONE with game_over=1; prev and row are unchanged.
- DONE:
  - All position outputs hold.
  - restart -> MOVE with curr=0, dir=right, prev=START_X, row=0, and win/game_over cleared.
  - drop is ignored.
- drop outside MOVE is ignored and not queued. restart outside DONE is ignored.
- Latency: drop to verdict visible (placed / game_over) = 3 clk edges (MOVE->LATCH->EVAL->registered output).
- check and placed are registered, state-decoded outputs; they are never combinational from inputs.

Decomposition:
- Shared package holds:
  - state encoding constants MOVE, LATCH, EVAL, DONE (2 bits);
  - BLOCK_W=10;
  - screen width 160.
- One sub-module is natural: tick_divider (parameter TICK_DIV, inputs clk/reset/clear, output tick).
- The sweep/FSM logic stays in block_drop_controller.

Test Plan:
- Reset mid-sweep (curr=40, state MOVE): assert reset asynchronously -> outputs immediately show curr=0, prev=75, row=0, and all flags are 0.
- TICK_DIV=4, row=0, no drop: curr goes 0,1,2… reaching 150 after 150 ticks, then goes to 149, 148 (dir flips at X_MAX); at 0 it flips back to right.
- Drop with curr=80, overlap_q driven 1 in EVAL: check high exactly 1 cycle, placed pulses 1 cycle, then prev=80, row=1, curr=0, state MOVE.
- Drop with curr=100, prev=75, overlap_q=0: game_over=1 on the 3rd edge after drop, row unchanged, and further drops are ignored; restart -> prev=75, row=0, game_over=0.
- Drop and tick in the same cycle at curr=20: curr stays 20 in LATCH, and drop during LATCH/EVAL causes no extra transition.
- ROWS=2, two successful drops: after the second, win=1, row=2, state DONE. With row=4, the step is 2 per tick, and at curr=149 dir right the next tick gives curr=150 (clamped).

Source files
------------

// File: rtl/block_drop_controller_pkg.sv
// Shared definitions for the block drop controller: FSM state encoding,
// block/screen geometry and the sweep step helper.
package block_drop_controller_pkg;

    // Controller phases: sweeping, frozen for the detector, judging, round over.
    typedef enum logic [1:0] {
        MOVE  = 2'd0,
        LATCH = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Block width and screen width in pixels.
    localparam int BLOCK_W  = 10;
    localparam int SCREEN_W = 160;

    // Position bus width and the wider width used for sweep arithmetic.
    localparam int POS_W   = 8;
    localparam int ARITH_W = 9;

    // Pixels moved per tick: 1 on the first four rows, then one faster every
    // four rows placed (1..4).
    function automatic logic [ARITH_W-1:0] step_size(input logic [3:0] rows_placed);
        return 9'd1 + {7'd0, rows_placed[3:2]};
    endfunction

endpackage

// File: rtl/block_drop_controller_tick_divider.sv
// Movement tick generator: one-cycle tick every TICK_DIV enabled cycles.
// While clear is high the counter sits at zero, so counting restarts from
// zero every time the controller re-enters its sweep phase.
module tick_divider #(
    parameter int TICK_DIV = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick      = w_at_last && !clear;

    // Count 0..TICK_DIV-1 while enabled, wrap on the tick, hold zero when cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/block_drop_controller.sv
// Moving-block producer for the stacking game: sweeps the current block
// between 0 and X_MAX, freezes it on a drop, hands the frozen positions to the
// overlap detector for one cycle, then commits the row or ends the round on
// the detector's registered verdict.
module block_drop_controller
    import block_drop_controller_pkg::*;
#(
    parameter int X_MAX    = SCREEN_W - BLOCK_W,
    parameter int START_X  = 75,
    parameter int TICK_DIV = 833333,
    parameter int ROWS     = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drop,
    input  logic       restart,
    input  logic       overlap_q,
    output logic [7:0] curr_x_position,
    output logic [7:0] prev_x_position,
    output logic [3:0] row,
    output logic       check,
    output logic       placed,
    output logic       game_over,
    output logic       win,
    output logic [1:0] o_dbg_state
);

    localparam logic [ARITH_W-1:0] XMAX9  = ARITH_W'(X_MAX);
    localparam logic [POS_W-1:0]   XMAX8  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]   START8 = POS_W'(START_X);
    localparam logic [3:0]         ROWS4  = 4'(ROWS);

    state_t           r_state;
    logic [POS_W-1:0] r_curr;
    logic [POS_W-1:0] r_prev;
    logic             r_right;
    logic [3:0]       r_row;
    logic             r_check;
    logic             r_placed;
    logic             r_game_over;
    logic             r_win;

    logic               w_tick;
    logic               w_tick_clear;
    logic [ARITH_W-1:0] w_step;
    logic [ARITH_W-1:0] w_curr9;
    logic [ARITH_W-1:0] w_sum;
    logic [POS_W-1:0]   w_next_curr;
    logic               w_next_right;
    logic [3:0]         w_row_inc;

    // The tick counter only runs during the sweep; any other phase holds it at zero.
    assign w_tick_clear = (r_state != MOVE);

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .clear (w_tick_clear),
        .tick  (w_tick)
    );

    assign w_step    = step_size(r_row);
    assign w_curr9   = {1'b0, r_curr};
    assign w_sum     = w_curr9 + w_step;
    assign w_row_inc = r_row + 4'd1;

    // Next sweep position: clamp at either wall and reverse direction there.
    always_comb begin
        w_next_curr  = r_curr;
        w_next_right = r_right;
        if (r_right) begin
            if (w_sum >= XMAX9) begin
                w_next_curr  = XMAX8;
                w_next_right = 1'b0;
            end else begin
                w_next_curr = w_sum[POS_W-1:0];
            end
        end else begin
            if (w_curr9 <= w_step) begin
                w_next_curr  = '0;
                w_next_right = 1'b1;
            end else begin
                w_next_curr = r_curr - w_step[POS_W-1:0];
            end
        end
    end

    // Round FSM with registered position, row and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= MOVE;
            r_curr      <= '0;
            r_right     <= 1'b1;
            r_prev      <= START8;
            r_row       <= '0;
            r_check     <= 1'b0;
            r_placed    <= 1'b0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            r_check  <= 1'b0;
            r_placed <= 1'b0;
            case (r_state)
                MOVE: begin
                    // A drop beats a coincident tick: the block freezes where it is.
                    if (drop) begin
                        r_state <= LATCH;
                        r_check <= 1'b1;
                    end else if (w_tick) begin
                        r_curr  <= w_next_curr;
                        r_right <= w_next_right;
                    end
                end
                LATCH: begin
                    // Positions held; the detector registers its verdict at this edge.
                    r_state <= EVAL;
                end
                EVAL: begin
                    if (overlap_q) begin
                        r_prev   <= r_curr;
                        r_row    <= w_row_inc;
                        r_placed <= 1'b1;
                        if (w_row_inc == ROWS4) begin
                            r_state <= DONE;
                            r_win   <= 1'b1;
                        end else begin
                            r_state <= MOVE;
                            r_curr  <= '0;
                            r_right <= 1'b1;
                        end
                    end else begin
                        r_state     <= DONE;
                        r_game_over <= 1'b1;
                    end
                end
                DONE: begin
                    if (restart) begin
                        r_state     <= MOVE;
                        r_curr      <= '0;
                        r_right     <= 1'b1;
                        r_prev      <= START8;
                        r_row       <= '0;
                        r_game_over <= 1'b0;
                        r_win       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= MOVE;
                end
            endcase
        end
    end

    assign curr_x_position = r_curr;
    assign prev_x_position = r_prev;
    assign row             = r_row;
    assign check           = r_check;
    assign placed          = r_placed;
    assign game_over       = r_game_over;
    assign win             = r_win;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_block_drop_controller.sv
// Bench for block_drop_controller: randomized drops/restarts/verdicts driven
// against a rule-level model; every cycle's expected outputs go into a queue
// that a negedge monitor drains and compares.
module tb_block_drop_controller;
    import block_drop_controller_pkg::*;

    localparam int TDIV   = 4;
    localparam int NROWS  = 5;
    localparam int XMAX   = 150;
    localparam int XSTART = 75;

    localparam int PH_SWEEP  = 0;
    localparam int PH_FROZEN = 1;
    localparam int PH_JUDGE  = 2;
    localparam int PH_END    = 3;

    localparam int OV_REAL = 0;
    localparam int OV_HIT  = 1;
    localparam int OV_MISS = 2;
    localparam int OV_COIN = 3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       drop;
    logic       restart;
    logic       overlap_q;
    logic [7:0] curr_x_position;
    logic [7:0] prev_x_position;
    logic [3:0] row;
    logic       check;
    logic       placed;
    logic       game_over;
    logic       win;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    block_drop_controller #(
        .X_MAX    (XMAX),
        .START_X  (XSTART),
        .TICK_DIV (TDIV),
        .ROWS     (NROWS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .drop            (drop),
        .restart         (restart),
        .overlap_q       (overlap_q),
        .curr_x_position (curr_x_position),
        .prev_x_position (prev_x_position),
        .row             (row),
        .check           (check),
        .placed          (placed),
        .game_over       (game_over),
        .win             (win),
        .o_dbg_state     (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors     = 0;
    int miscompares = 0;

    logic [57:0] exp_q[$];
    logic [25:0] w_got;
    assign w_got = {curr_x_position, prev_x_position, row, check, placed, game_over, win, dbg_state};

    // ---------------- reference model ----------------
    int m_curr, m_prev, m_row, m_tcnt, m_phase;
    bit m_right, m_placed, m_over, m_win;

    task automatic model_reset();
        m_curr   = 0;
        m_prev   = XSTART;
        m_row    = 0;
        m_tcnt   = 0;
        m_phase  = PH_SWEEP;
        m_right  = 1'b1;
        m_placed = 1'b0;
        m_over   = 1'b0;
        m_win    = 1'b0;
    endtask

    function automatic bit blocks_overlap();
        int d;
        d = (m_curr > m_prev) ? (m_curr - m_prev) : (m_prev - m_curr);
        return d < BLOCK_W;
    endfunction

    // One clock edge of the game rules, given the inputs present at that edge.
    task automatic model_edge(input bit d, input bit rs, input bit ov);
        int step;
        m_placed = 1'b0;
        case (m_phase)
            PH_SWEEP: begin
                if (d) begin
                    m_phase = PH_FROZEN;
                    m_tcnt  = 0;
                end else if (m_tcnt == TDIV - 1) begin
                    m_tcnt = 0;
                    step   = 1 + m_row / 4;
                    if (m_right) begin
                        if (m_curr + step >= XMAX) begin
                            m_curr  = XMAX;
                            m_right = 1'b0;
                        end else begin
                            m_curr = m_curr + step;
                        end
                    end else begin
                        if (m_curr <= step) begin
                            m_curr  = 0;
                            m_right = 1'b1;
                        end else begin
                            m_curr = m_curr - step;
                        end
                    end
                end else begin
                    m_tcnt = m_tcnt + 1;
                end
            end
            PH_FROZEN: m_phase = PH_JUDGE;
            PH_JUDGE: begin
                if (ov) begin
                    m_prev   = m_curr;
                    m_row    = m_row + 1;
                    m_placed = 1'b1;
                    if (m_row == NROWS) begin
                        m_phase = PH_END;
                        m_win   = 1'b1;
                    end else begin
                        m_phase = PH_SWEEP;
                        m_curr  = 0;
                        m_right = 1'b1;
                        m_tcnt  = 0;
                    end
                end else begin
                    m_phase = PH_END;
                    m_over  = 1'b1;
                end
            end
            default: begin
                if (rs) model_reset();
            end
        endcase
    endtask

    function automatic logic [25:0] model_vec();
        logic [1:0] st;
        case (m_phase)
            PH_SWEEP:  st = MOVE;
            PH_FROZEN: st = LATCH;
            PH_JUDGE:  st = EVAL;
            default:   st = DONE;
        endcase
        return {8'(m_curr), 8'(m_prev), 4'(m_row), (m_phase == PH_FROZEN), m_placed, m_over, m_win, st};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic compare(input string name, input logic [25:0] got, input logic [25:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got curr=%0d prev=%0d row=%0d check=%0b placed=%0b game_over=%0b win=%0b state=%0d | expected curr=%0d prev=%0d row=%0d check=%0b placed=%0b game_over=%0b win=%0b state=%0d",
                     name, cyc, got[25:18], got[17:10], got[9:6], got[5], got[4], got[3], got[2], got[1:0],
                     exp[25:18], exp[17:10], exp[9:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [57:0] e;
        while (exp_q.size() > 0 && int'(exp_q[0][57:26]) <= cyc) begin
            e = exp_q.pop_front();
            if (int'(e[57:26]) != cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL stale_entry cyc=%0d entry for cyc %0d never observed", cyc, int'(e[57:26]));
            end else begin
                compare("cycle_outputs", w_got, e[25:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit d, input bit rs, input int ov_mode);
        drop    = d;
        restart = rs;
        if (m_phase == PH_JUDGE) begin
            case (ov_mode)
                OV_HIT:  overlap_q = 1'b1;
                OV_MISS: overlap_q = 1'b0;
                OV_COIN: overlap_q = 1'($urandom_range(0, 1));
                default: overlap_q = blocks_overlap();
            endcase
        end else begin
            overlap_q = 1'($urandom_range(0, 1));
        end
        model_edge(d, rs, overlap_q);
        exp_q.push_back({32'(cyc + 1), model_vec()});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2;
        reset   = 1'b1;
        drop    = 1'b0;
        restart = 1'b0;
        #1;
        compare("async_reset", w_got, {8'd0, 8'(XSTART), 4'd0, 4'b0000, MOVE});
        exp_q.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_until(input int target, input bit need_tick, input int bound);
        int n;
        n = 0;
        while (!(m_phase == PH_SWEEP && m_curr == target && (!need_tick || m_tcnt == TDIV - 1))
               && n < bound) begin
            cycle(1'b0, 1'b0, OV_REAL);
            n++;
        end
        if (n >= bound) begin
            vectors++;
            miscompares++;
            $display("FAIL run_until target=%0d not reached in %0d cycles (model curr=%0d)", target, bound, m_curr);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pos;
        reset     = 1'b1;
        drop      = 1'b0;
        restart   = 1'b0;
        overlap_q = 1'b0;
        #2;
        compare("reset_state", w_got, {8'd0, 8'(XSTART), 4'd0, 4'b0000, MOVE});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Full bounce at step 1: 0 -> 150 -> 0 and back to the right.
        for (int i = 0; i < TDIV * 320; i++) cycle(1'b0, 1'b0, OV_REAL);

        // Asynchronous reset in the middle of a sweep.
        run_until(40, 1'b0, 2000);
        reset_dut();

        // Successful drop at 80, with extra drops during LATCH and EVAL.
        run_until(80, 1'b0, 2000);
        cycle(1'b1, 1'b0, OV_HIT);
        cycle(1'b1, 1'b0, OV_HIT);
        cycle(1'b1, 1'b0, OV_HIT);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, OV_REAL);

        // Drop coinciding with a tick at 20.
        run_until(20, 1'b1, 2000);
        cycle(1'b1, 1'b0, OV_HIT);
        cycle(1'b1, 1'b0, OV_HIT);
        cycle(1'b1, 1'b0, OV_HIT);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, OV_REAL);

        // Miss at 100 against the base at 75, drops ignored in DONE, restart.
        reset_dut();
        run_until(100, 1'b0, 2000);
        cycle(1'b1, 1'b0, OV_REAL);
        cycle(1'b0, 1'b0, OV_REAL);
        cycle(1'b0, 1'b0, OV_REAL);
        for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 1'b0, OV_REAL);
        cycle(1'b0, 1'b1, OV_REAL);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, OV_REAL);

        // Climb to a win; full sweep at row 4 exercises step 2 and clamping.
        for (int k = 0; k < NROWS; k++) begin
            if (k == NROWS - 1) begin
                for (int i = 0; i < TDIV * 160; i++) cycle(1'b0, 1'b0, OV_REAL);
            end
            pos = 2 * int'($urandom_range(3, 70));
            run_until(pos, 1'b0, 3000);
            cycle(1'b1, 1'b0, OV_HIT);
            cycle(1'b0, 1'b0, OV_HIT);
            cycle(1'b0, 1'b0, OV_HIT);
        end
        for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 1'b0, OV_REAL);
        cycle(1'b0, 1'b1, OV_REAL);

        // Random play: sparse drops, random verdicts, stray restarts.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) reset_dut();
            cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 1) == 0) ? OV_COIN : OV_REAL);
        end

        cycle(1'b0, 1'b0, OV_REAL);
        drop    = 1'b0;
        restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL queue_drain got %0d pending entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
